a2d_chan_sched: RTL

- Scheduler for the shared A2D SPI path (SPI master → ADC128S) that feeds load cells, steering pot and battery readings to the Segway core.
- On each trigger it sweeps all four channels in fixed order, issuing the two-transaction ADC128S read for each.
- Captures each 12-bit result into a dedicated output register.
- Accepts a one-deep pending trigger and an urgent battery request that preempts the next sweep slot.

---
 rtl/a2d_sched_pkg.sv | 20 ++
 rtl/a2d_chan_sched.sv | 131 +++++++++++++
 2 files changed

// File: rtl/a2d_sched_pkg.sv
// a2d_sched_pkg: shared types and helpers for the A2D channel scheduler
package a2d_sched_pkg;

    typedef enum logic [2:0] {IDLE, SEND1, WAIT1, GAP, SEND2, WAIT2, NEXT} state_t;

    typedef enum logic [1:0] {SLOT_LFT, SLOT_RGHT, SLOT_STEER, SLOT_BATT} slot_t;

    // ADC128S control word: channel address lives in bits [13:11]
    function automatic logic [15:0] cmd_build(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    // Two-tap average with a 13-bit intermediate so the carry is kept before halving
    function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12:1];
    endfunction

endpackage

// File: rtl/a2d_chan_sched.sv
// a2d_chan_sched: sweeps the four ADC128S channels over the shared SPI master; A2D_AVG_EN enables load-cell averaging
module a2d_chan_sched
    import a2d_sched_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        batt_req,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        sweep_done,
    output logic        busy
);

    state_t      state, state_nx;
    slot_t       slot, pick;
    logic [1:0]  idx;
    logic [3:0]  rd;
    logic        pending;
    logic        start;
    logic [11:0] lft_new, rght_new;
    logic        unused_resp_hi;

    assign unused_resp_hi = ^resp[15:12];

    function automatic logic [2:0] slot_ch(input slot_t s);
        return s == SLOT_LFT ? CH_LFT : s == SLOT_RGHT ? CH_RGHT : s == SLOT_STEER ? CH_STEER : CH_BATT;
    endfunction

    // Battery jumps the queue once per sweep; otherwise take the first channel not yet read
    always_comb begin
        pick = (batt_req && !rd[SLOT_BATT]) ? SLOT_BATT :
               !rd[SLOT_LFT]   ? SLOT_LFT :
               !rd[SLOT_RGHT]  ? SLOT_RGHT :
               !rd[SLOT_STEER] ? SLOT_STEER : SLOT_BATT;
    end

    // Next-state logic for the two-transaction-per-channel sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (nxt || pending) ? SEND1 : IDLE;
            SEND1:   state_nx = WAIT1;
            WAIT1:   state_nx = done ? GAP : WAIT1;
            GAP:     state_nx = SEND2;
            SEND2:   state_nx = WAIT2;
            WAIT2:   state_nx = done ? NEXT : WAIT2;
            NEXT:    state_nx = (idx == 2'd3) ? IDLE : SEND1;
            default: state_nx = IDLE;
        endcase
    end

    assign start      = (state_nx == SEND1) && (state == IDLE || state == NEXT);
    assign wrt        = (state == SEND1) || (state == SEND2);
    assign sweep_done = (state == NEXT) && (idx == 2'd3);
    assign busy       = (state != IDLE) && !sweep_done;

`ifdef A2D_AVG_EN
    logic lft_seen, rght_seen;
    assign lft_new  = lft_seen  ? avg12(lft_ld,  resp[11:0]) : resp[11:0];
    assign rght_new = rght_seen ? avg12(rght_ld, resp[11:0]) : resp[11:0];
`else
    assign lft_new  = resp[11:0];
    assign rght_new = resp[11:0];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Slot bookkeeping, command word and one-deep trigger queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= SLOT_LFT;
            cmd     <= 16'h0000;
            rd      <= 4'b0000;
            idx     <= 2'd0;
            pending <= 1'b0;
        end else begin
            if (start) begin
                slot <= pick;
                cmd  <= cmd_build(slot_ch(pick));
                rd   <= rd | (4'b0001 << pick);
            end
            if (sweep_done) rd <= 4'b0000;
            if (state == IDLE) idx <= 2'd0;
            else if (state == NEXT && idx != 2'd3) idx <= idx + 2'd1;
            if (state == IDLE) pending <= 1'b0;
            else if (nxt) pending <= 1'b1;
        end
    end

    // Capture the second transaction's data into the register of the slot in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
`ifdef A2D_AVG_EN
            lft_seen  <= 1'b0;
            rght_seen <= 1'b0;
`endif
        end else if (state == WAIT2 && done) begin
            case (slot)
                SLOT_LFT:   lft_ld    <= lft_new;
                SLOT_RGHT:  rght_ld   <= rght_new;
                SLOT_STEER: steer_pot <= resp[11:0];
                default:    batt      <= resp[11:0];
            endcase
`ifdef A2D_AVG_EN
            if (slot == SLOT_LFT)  lft_seen  <= 1'b1;
            if (slot == SLOT_RGHT) rght_seen <= 1'b1;
`endif
        end
    end

endmodule
